// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the fetch stage and the memory stage (data has priority).
// Define MEM_ARB_FAIR_EN to force a fetch grant after STARVE_MAX consecutive data grants.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   // fetch stage
   input  logic                    InstrReqF,
   input  logic [ADDR_WIDTH-1:0]   PCF,
   input  logic                    FetchKillF,
   output logic [DATA_WIDTH-1:0]   InstrF,
   output logic                    InstrValidF,
   // memory stage
   input  logic                    MemReqM,
   input  logic                    MemWriteM,
   input  logic [ADDR_WIDTH-1:0]   ALUResultM,
   input  logic [DATA_WIDTH-1:0]   WriteDataM,
   input  logic [DATA_WIDTH/8-1:0] ByteEnM,
   output logic [DATA_WIDTH-1:0]   ReadDataM,
   output logic                    MemDoneM,
   // hazard unit
   output logic                    StallFetch,
   output logic                    StallMem,
   // memory port
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_be,
   input  logic                    mem_ack,
   input  logic [DATA_WIDTH-1:0]   mem_rdata
);

   localparam int BE_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DATA  = 2'd2
   } state_t;

   state_t                 state_reg, state_next;
   logic [ADDR_WIDTH-1:0]  addr_reg, addr_next;
   logic [DATA_WIDTH-1:0]  wdata_reg, wdata_next;
   logic [BE_WIDTH-1:0]    be_reg, be_next;
   logic                   we_reg, we_next;
   logic                   kill_reg, kill_next;
   logic [DATA_WIDTH-1:0]  instr_reg, instr_next;
   logic [DATA_WIDTH-1:0]  rdata_reg, rdata_next;

   logic                   grant_fetch;
   logic                   grant_data;
   logic                   fetch_ok;
   logic                   fetch_first;
   logic                   killed;
   logic [BE_WIDTH-1:0]    be_grant;

   // Loads drive every lane; only stores honour the requested byte enables.
   genvar gi;
   generate
      for (gi = 0; gi < BE_WIDTH; gi++) begin : g_be
         assign be_grant[gi] = MemWriteM ? ByteEnM[gi] : 1'b1;
      end
   endgenerate

   assign fetch_ok = InstrReqF && !FetchKillF;

`ifdef MEM_ARB_FAIR_EN
   localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

   logic [CNT_W-1:0] starve_reg, starve_next;
   logic             starve_hit;

   assign starve_hit  = (starve_reg == CNT_W'(STARVE_MAX));
   assign fetch_first = starve_hit && fetch_ok;

   // Saturates at STARVE_MAX so a killed fetch cannot wrap the count.
   always_comb begin
      starve_next = starve_reg;
      if (grant_fetch) begin
         starve_next = '0;
      end else if (grant_data && InstrReqF && !starve_hit) begin
         starve_next = starve_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_reg <= '0;
      end else begin
         starve_reg <= starve_next;
      end
   end
`else
   logic unused_starve;

   assign fetch_first   = 1'b0;
   assign unused_starve = (STARVE_MAX != 0);
`endif

   assign killed      = kill_reg || FetchKillF;
   assign InstrValidF = (state_reg == FETCH) && mem_ack && !killed;
   assign MemDoneM    = (state_reg == DATA) && mem_ack;

   always_comb begin
      state_next  = state_reg;
      addr_next   = addr_reg;
      wdata_next  = wdata_reg;
      be_next     = be_reg;
      we_next     = we_reg;
      kill_next   = 1'b0;
      instr_next  = instr_reg;
      rdata_next  = rdata_reg;
      grant_fetch = 1'b0;
      grant_data  = 1'b0;

      unique case (state_reg)
         IDLE: begin
            if (fetch_first) begin
               grant_fetch = 1'b1;
            end else if (MemReqM) begin
               grant_data = 1'b1;
            end else if (fetch_ok) begin
               grant_fetch = 1'b1;
            end

            if (grant_data) begin
               state_next = DATA;
               addr_next  = ALUResultM;
               wdata_next = WriteDataM;
               we_next    = MemWriteM;
               be_next    = be_grant;
            end else if (grant_fetch) begin
               state_next = FETCH;
               addr_next  = PCF;
               wdata_next = '0;
               we_next    = 1'b0;
               be_next    = '1;
            end
         end

         FETCH: begin
            kill_next = kill_reg || FetchKillF;
            if (mem_ack) begin
               state_next = IDLE;
               kill_next  = 1'b0;
            end
         end

         DATA: begin
            if (mem_ack) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      if (InstrValidF) begin
         instr_next = mem_rdata;
      end
      if (MemDoneM && !we_reg) begin
         rdata_next = mem_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         addr_reg  <= '0;
         wdata_reg <= '0;
         be_reg    <= '0;
         we_reg    <= 1'b0;
         kill_reg  <= 1'b0;
         instr_reg <= '0;
         rdata_reg <= '0;
      end else begin
         state_reg <= state_next;
         addr_reg  <= addr_next;
         wdata_reg <= wdata_next;
         be_reg    <= be_next;
         we_reg    <= we_next;
         kill_reg  <= kill_next;
         instr_reg <= instr_next;
         rdata_reg <= rdata_next;
      end
   end

   // Write enable is gated so a stale store flag never leaks onto an idle port.
   assign mem_req   = (state_reg != IDLE);
   assign mem_we    = mem_req && we_reg;
   assign mem_addr  = addr_reg;
   assign mem_wdata = wdata_reg;
   assign mem_be    = be_reg;

   assign InstrF    = InstrValidF ? mem_rdata : instr_reg;
   assign ReadDataM = (MemDoneM && !we_reg) ? mem_rdata : rdata_reg;

   assign StallFetch = InstrReqF && !InstrValidF;
   assign StallMem   = MemReqM && !MemDoneM;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, memory byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, memory data width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, maximum consecutive data grants while fetch waits (fair build only).
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 InstrReqF  in  1  fetch stage requests instruction at PCF.
REQ-007 PCF  in  ADDR_WIDTH  fetch address.
REQ-008 FetchKillF  in  1  discard in-flight fetch (branch/flush).
REQ-009 InstrF  out  DATA_WIDTH  fetched instruction.
REQ-010 InstrValidF  out  1  InstrF valid this cycle.
REQ-011 MemReqM  in  1  memory stage requests load/store.
REQ-012 MemWriteM  in  1  1 = store, 0 = load.
REQ-013 ALUResultM  in  ADDR_WIDTH  data address.
REQ-014 WriteDataM  in  DATA_WIDTH  store data.
REQ-015 ByteEnM  in  DATA_WIDTH/8  store byte enables.
REQ-016 ReadDataM  out  DATA_WIDTH  load data.
REQ-017 MemDoneM  out  1  data access completes this cycle.
REQ-018 StallFetch  out  1  fetch request not yet served; to hazard unit.
REQ-019 StallMem  out  1  data request not yet served; to hazard unit.
REQ-020 mem_req, mem_we  out  1 each  memory-port request, write enable.
REQ-021 mem_addr  out  ADDR_WIDTH; mem_wdata  out  DATA_WIDTH; mem_be  out  DATA_WIDTH/8.
REQ-022 mem_ack  in  1  port completes access; mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack.

Function
REQ-023 FSM states SHALL be IDLE, FETCH, DATA.
REQ-024 IDLE: MemReqM -> DATA; else InstrReqF -> FETCH; else stay (data has priority).
REQ-025 FETCH/DATA: mem_req = 1; addr/we/wdata/be SHALL come from registers latched at grant and held stable until mem_ack.
REQ-026 FETCH: mem_we = 0, mem_be all ones; DATA load: mem_we = 0, mem_be all ones; DATA store: mem_we = 1, mem_be = ByteEnM.
REQ-027 On mem_ack, FSM SHALL return to IDLE (one arbitration cycle between accesses); no direct FETCH->DATA transition.
REQ-028 Minimum latency: request in IDLE cycle N, mem_req in N+1, completion in N+1 if mem_ack in N+1.
REQ-029 MemDoneM = (state==DATA && mem_ack); ReadDataM = mem_rdata in that cycle, else last captured load data.
REQ-030 InstrValidF = (state==FETCH && mem_ack && !killed); InstrF = mem_rdata in that cycle, else held.
REQ-031 FetchKillF in any cycle of FETCH SHALL set a kill flag; bus access completes normally, InstrValidF suppressed; flag cleared on return to IDLE.
REQ-032 FetchKillF in IDLE SHALL suppress a fetch grant that cycle.
REQ-033 StallMem = MemReqM && !MemDoneM; StallFetch = InstrReqF && !InstrValidF.
REQ-034 mem_ack while IDLE SHALL be ignored.

Reset
REQ-035 rst_n low SHALL immediately force IDLE, mem_req/mem_we = 0, mem_addr/mem_wdata/mem_be = 0, InstrValidF/MemDoneM = 0, InstrF/ReadDataM = 0, kill flag and starve counter = 0.
REQ-036 Reset mid-access SHALL abandon the access; first grant possible in the first cycle after rst_n rises.

Configuration
REQ-037 Macro MEM_ARB_FAIR_EN defined: counter increments per data grant while InstrReqF high, clears on fetch grant; when count == STARVE_MAX, IDLE SHALL grant FETCH even with MemReqM high.
REQ-038 MEM_ARB_FAIR_EN undefined: strict data priority, no counter logic; STARVE_MAX unused.

Verification
REQ-039 InstrReqF=1, PCF=0x100, mem_ack 1 cycle after mem_req, mem_rdata=0x00500093 -> mem_addr=0x100, InstrValidF pulse, InstrF=0x00500093, StallFetch low that cycle.
REQ-040 InstrReqF and MemReqM both high in IDLE, load at 0x2000 -> DATA granted first, MemDoneM before fetch served; StallFetch high throughout.
REQ-041 Store 0xDEADBEEF, ByteEnM=0x3, mem_ack delayed 3 cycles -> mem_we=1, mem_be=0x3, controls stable for all 3 wait cycles, StallMem high until ack cycle.
REQ-042 FetchKillF pulsed mid-FETCH -> mem_ack completes, InstrValidF stays 0, FSM back to IDLE next cycle.
REQ-043 rst_n low during DATA wait -> mem_req drops same cycle, all outputs 0, next request granted after release.
REQ-044 MEM_ARB_FAIR_EN, STARVE_MAX=4, MemReqM and InstrReqF held high -> 4 data grants then 1 fetch grant, pattern repeats.
